// File: rtl/key_request_capture.sv
// key_request_capture
//   Captures debounced rising edges on eight raw key inputs and presents them,
//   one at a time, as a one-hot request to a downstream 8-to-3 encoder using a
//   valid/ready handshake. Presses not yet issued are held in a pending mask;
//   higher key indices issue first.
//
// Parameters
//   DB_CYCLES   debounce length in clk cycles (2 .. 2^24-1)
//
// Ports
//   clk         system clock, rising-edge
//   rst_n       asynchronous active-low reset
//   key_raw     raw asynchronous key levels, bit i is key i
//   onehot_out  registered one-hot request, all-zero when out_valid=0
//   out_valid   onehot_out holds a valid request
//   out_ready   downstream accepts onehot_out when out_valid=1
//   pending     captured presses not yet issued
//   overrun     one-cycle pulse when a press is lost
module key_request_capture #(
  parameter int unsigned DB_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_raw,
  output logic [7:0] onehot_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pending,
  output logic       overrun
);

  localparam int unsigned NKEYS = 8;
  localparam int unsigned CW    = 24;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  // Synchronizer and debounce state
  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] sync2;
  logic [NKEYS-1:0] stable;
  logic [CW-1:0]    cnt [NKEYS];

  // Combinational helpers
  logic [NKEYS-1:0] rise;      // stable[i] goes 0->1 on this edge
  logic [NKEYS-1:0] sel;       // one-hot of highest-index pending bit
  logic [NKEYS-1:0] clr;       // pending bit consumed by a load this edge
  logic [NKEYS-1:0] pend_nxt;
  logic             out_free;
  logic             lost;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-key debounce: the counter runs only while the synchronized level
  // disagrees with the debounced level; DB_CYCLES consecutive mismatching
  // cycles are needed before stable follows.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NKEYS; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    rise = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      rise[i] = sync2[i] & ~stable[i] & (cnt[i] == DB_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Output selection: ascending scan so the last hit (highest index) wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (pending[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

  assign out_free = ~out_valid | out_ready;
  assign clr      = out_free ? sel : '0;

  // A rise on the same edge as the clear re-arms the bit, so OR the rise in
  // after the clear.
  assign pend_nxt = (pending & ~clr) | rise;

  // Press lost: rise onto a bit that is already pending and not being consumed.
  assign lost     = |(rise & pending & ~clr);

  // ---------------------------------------------------------------------------
  // Pending mask, output register and overrun pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      onehot_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pending <= pend_nxt;
      overrun <= lost;
      if (out_free) begin
        if (|pending) begin
          onehot_out <= sel;
          out_valid  <= 1'b1;
        end else begin
          onehot_out <= '0;
          out_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_request_capture.sv
module tb_key_request_capture;

  logic       clk;
  logic       rst_n;
  logic [7:0] key_raw;
  logic [7:0] onehot_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       overrun;

  int checks;
  int fails;

  key_request_capture #(.DB_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .onehot_out (onehot_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pending    (pending),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; key_raw = 8'h00; out_ready = 1'b0;
    step(2);
    checks++; if (onehot_out !== 8'h00) begin fails++; $display("FAIL reset_onehot got=%h exp=00", onehot_out); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (pending !== 8'h00) begin fails++; $display("FAIL reset_pending got=%h exp=00", pending); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    rst_n = 1'b1;
    step(1);
  endtask

  // key 2 pressed: pending after E0+5, valid after E0+6, gone after E0+7
  task automatic test_latency;
    key_raw = 8'h04; out_ready = 1'b1;
    for (int n = 0; n <= 5; n++) begin
      step(1);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_early_valid edge=%0d got=%b exp=0", n, out_valid); end
    end
    checks++; if (pending !== 8'h04) begin fails++; $display("FAIL latency_pending got=%h exp=04", pending); end
    step(1);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL latency_valid got=%b exp=1", out_valid); end
    checks++; if (onehot_out !== 8'h04) begin fails++; $display("FAIL latency_onehot got=%h exp=04", onehot_out); end
    checks++; if (pending !== 8'h00) begin fails++; $display("FAIL latency_pending_clr got=%h exp=00", pending); end
    step(1);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_drop_valid got=%b exp=0", out_valid); end
    checks++; if (onehot_out !== 8'h00) begin fails++; $display("FAIL latency_drop_onehot got=%h exp=00", onehot_out); end
    key_raw = 8'h00;
    step(10);
  endtask

  task automatic test_bounce;
    out_ready = 1'b1;
    key_raw = 8'h04; step(1);
    key_raw = 8'h00; step(1);
    key_raw = 8'h04; step(1);
    key_raw = 8'h00; step(1);
    for (int n = 0; n < 10; n++) begin
      step(1);
      checks++; if (dut.stable[2] !== 1'b0) begin fails++; $display("FAIL bounce_stable cyc=%0d got=%b exp=0", n, dut.stable[2]); end
      checks++; if (pending !== 8'h00) begin fails++; $display("FAIL bounce_pending cyc=%0d got=%h exp=00", n, pending); end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bounce_valid cyc=%0d got=%b exp=0", n, out_valid); end
    end
  endtask

  task automatic test_simultaneous;
    key_raw = 8'h81; out_ready = 1'b1;
    step(6);
    checks++; if (pending !== 8'h81) begin fails++; $display("FAIL simul_pending got=%h exp=81", pending); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL simul_early_valid got=%b exp=0", out_valid); end
    step(1);
    checks++; if (onehot_out !== 8'h80) begin fails++; $display("FAIL simul_first got=%h exp=80", onehot_out); end
    checks++; if (pending !== 8'h01) begin fails++; $display("FAIL simul_pending_rem got=%h exp=01", pending); end
    step(1);
    checks++; if (onehot_out !== 8'h01) begin fails++; $display("FAIL simul_second got=%h exp=01", onehot_out); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL simul_second_valid got=%b exp=1", out_valid); end
    step(1);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL simul_end_valid got=%b exp=0", out_valid); end
    key_raw = 8'h00;
    step(10);
  endtask

  task automatic test_hold_overrun;
    int ov;
    out_ready = 1'b0; key_raw = 8'h10;
    step(7);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_valid got=%b exp=1", out_valid); end
    checks++; if (onehot_out !== 8'h10) begin fails++; $display("FAIL hold_onehot got=%h exp=10", onehot_out); end
    key_raw = 8'h00;
    step(8);
    checks++; if (onehot_out !== 8'h10) begin fails++; $display("FAIL hold_release_onehot got=%h exp=10", onehot_out); end
    checks++; if (pending !== 8'h00) begin fails++; $display("FAIL hold_release_pending got=%h exp=00", pending); end
    key_raw = 8'h10; ov = 0;
    for (int n = 0; n < 8; n++) begin step(1); if (overrun === 1'b1) ov++; end
    checks++; if (ov !== 0) begin fails++; $display("FAIL repress_overrun got=%0d cycles exp=0", ov); end
    checks++; if (pending !== 8'h10) begin fails++; $display("FAIL repress_pending got=%h exp=10", pending); end
    checks++; if (onehot_out !== 8'h10) begin fails++; $display("FAIL repress_onehot got=%h exp=10", onehot_out); end
    key_raw = 8'h00;
    step(8);
    key_raw = 8'h10; ov = 0;
    for (int n = 0; n < 8; n++) begin step(1); if (overrun === 1'b1) ov++; end
    checks++; if (ov !== 1) begin fails++; $display("FAIL overrun_pulse got=%0d cycles exp=1", ov); end
    checks++; if (pending !== 8'h10) begin fails++; $display("FAIL overrun_pending got=%h exp=10", pending); end
    checks++; if (onehot_out !== 8'h10) begin fails++; $display("FAIL overrun_onehot got=%h exp=10", onehot_out); end
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL overrun_valid got=%b exp=1", out_valid); end
    // drain: held request accepted, pending key 4 reissues, then idle
    key_raw = 8'h00; out_ready = 1'b1;
    step(1);
    checks++; if (onehot_out !== 8'h10 || out_valid !== 1'b1) begin fails++; $display("FAIL drain_reissue got=%h/%b exp=10/1", onehot_out, out_valid); end
    checks++; if (pending !== 8'h00) begin fails++; $display("FAIL drain_pending got=%h exp=00", pending); end
    step(1);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_idle got=%b exp=0", out_valid); end
    step(6);
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b0; key_raw = 8'h08;
    step(7);
    checks++; if (onehot_out !== 8'h08) begin fails++; $display("FAIL mid_onehot got=%h exp=08", onehot_out); end
    key_raw = 8'h2a;
    step(7);
    checks++; if (pending !== 8'h22) begin fails++; $display("FAIL mid_pending got=%h exp=22", pending); end
    rst_n = 1'b0; key_raw = 8'h00;
    #1;
    checks++; if (onehot_out !== 8'h00) begin fails++; $display("FAIL mid_rst_onehot got=%h exp=00", onehot_out); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    checks++; if (pending !== 8'h00) begin fails++; $display("FAIL mid_rst_pending got=%h exp=00", pending); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL mid_rst_overrun got=%b exp=0", overrun); end
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      step(1);
      checks++; if (out_valid !== 1'b0 || pending !== 8'h00) begin fails++; $display("FAIL post_rst_idle cyc=%0d got=%b/%h exp=0/00", n, out_valid, pending); end
    end
  endtask

  task automatic test_held_after_reset;
    key_raw = 8'h01; out_ready = 1'b1;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int n = 0; n <= 5; n++) begin
      step(1);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL held_early_valid edge=%0d got=%b exp=0", n, out_valid); end
    end
    step(1);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL held_valid got=%b exp=1", out_valid); end
    checks++; if (onehot_out !== 8'h01) begin fails++; $display("FAIL held_onehot got=%h exp=01", onehot_out); end
    key_raw = 8'h00;
    step(8);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n = 1'b0; key_raw = 8'h00; out_ready = 1'b0;
    test_reset();
    test_latency();
    test_bounce();
    test_simultaneous();
    test_hold_overrun();
    test_reset_midflight();
    test_held_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/key_request_capture.md
KEY_REQUEST_CAPTURE -- requirements
Module: key_request_capture

Interface
REQ-001 Parameter DB_CYCLES, default 100000, sets debounce length in clk cycles (1 ms at 100 MHz); legal range 2 to 2^24-1.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 key_raw  input  8  asynchronous raw switch/button levels; bit i is key i.
REQ-005 onehot_out  output  8  registered one-hot request for the downstream 8-to-3 encoder; all-zero when out_valid=0.
REQ-006 out_valid  output  1  onehot_out holds a valid request.
REQ-007 out_ready  input  1  downstream accepts onehot_out in any cycle where out_valid=1 and out_ready=1.
REQ-008 pending  output  8  captured key presses not yet issued on onehot_out.
REQ-009 overrun  output  1  one-cycle pulse when a press is lost.

Function
REQ-010 Each key_raw bit SHALL pass through a 2-flop synchronizer (sync1, then sync2) before any other use.
REQ-011 Each bit SHALL have its own debounce counter and its own debounced level stable[i].
REQ-012 Counter i SHALL clear whenever sync2[i]==stable[i], and SHALL increment otherwise.
REQ-013 stable[i] SHALL take the value of sync2[i], and counter i SHALL clear, on the edge where a mismatch persists and counter i==DB_CYCLES-1.
REQ-014 Any bounce shorter than DB_CYCLES consecutive mismatching cycles SHALL leave stable[i] unchanged.
REQ-015 A 0->1 transition of stable[i] SHALL set pending[i] on the same edge; a 1->0 transition SHALL have no effect.
REQ-016 The output register SHALL be free when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-017 When the output register is free and pending is non-zero, it SHALL load the one-hot of the highest-index set pending bit, set out_valid, and clear that pending bit, all on the same edge.
REQ-018 When the output register is free and pending is zero, it SHALL clear out_valid and drive onehot_out to 8'h00.
REQ-019 onehot_out SHALL stay constant while out_valid=1 and out_ready=0.
REQ-020 onehot_out SHALL never have more than one bit set.
REQ-021 If pending[i] is cleared by a load and a new rise on bit i occurs on the same edge, pending[i] SHALL remain 1.
REQ-022 If a rise on bit i occurs while pending[i] is already 1 and is not being cleared, overrun SHALL pulse for exactly one cycle and pending[i] SHALL stay 1.
REQ-023 Latency: for a clean level change first sampled at edge E0, out_valid SHALL assert after edge E0+DB_CYCLES+2, provided the output register is free and no higher-index key is pending.
REQ-024 Independent keys SHALL debounce concurrently; simultaneous rises SHALL all set pending, and each SHALL then issue one per free cycle in descending index order.

Reset
REQ-025 While rst_n=0, the block SHALL clear sync1, sync2, stable, all counters, pending, onehot_out, out_valid and overrun to 0.
REQ-026 Asserting rst_n mid-debounce or mid-handshake SHALL discard all captured and in-flight presses.
REQ-027 After rst_n deasserts, a key already held high SHALL be treated as a fresh press and SHALL issue after the REQ-023 latency.

Verification (DB_CYCLES=4)
REQ-028 Scenario: key_raw=8'h04 from edge E0, out_ready=1 -> out_valid=1 and onehot_out=8'h04 after edge E0+6, then out_valid=0 on the next cycle.
REQ-029 Scenario: key_raw[2] toggles 1,0,1,0 each cycle, then returns to 0 -> stable, pending and out_valid all stay 0.
REQ-030 Scenario: key_raw=8'h81 applied on a single edge, out_ready=1 -> onehot_out issues 8'h80 then 8'h01 on consecutive cycles.
REQ-031 Scenario: out_ready=0 with onehot_out=8'h10 held; key 4 is released, then pressed again cleanly -> pending[4]=1 with no overrun.
REQ-032 Scenario: continuing REQ-031, key 4 is released and pressed once more while still held off -> overrun pulses for 1 cycle and onehot_out remains 8'h10.
REQ-033 Scenario: rst_n=0 for 1 cycle with out_valid=1 and pending=8'h22 -> all outputs read 0 immediately, and no request issues afterward while key_raw=0.
